// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8-entry scoreboarded register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 4;

    typedef logic [IDX_W-1:0]    reg_idx_t;
    typedef logic [NUM_REGS-1:0] busy_vec_t;

endpackage : regfile_pkg

// File: rtl/regfile8_scoreboard_mux8.sv
// 8:1 mux selecting one register's data from the storage array.
module regfile8_scoreboard_mux8
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0]               sel,
    output logic [WIDTH-1:0]               data_out
);

    // Plain indexed select; index range covers every entry.
    always_comb begin
        data_out = data_in[sel];
    end

endmodule : regfile8_scoreboard_mux8

// File: rtl/regfile8_scoreboard.sv
// 8-entry register file with per-register busy bits, two bypassed read ports,
// one reserving issue port and one clearing writeback port.
module regfile8_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rd_a_sel,
    output logic [WIDTH-1:0] rd_a_data,
    output logic             rd_a_busy,
    input  logic [2:0]       rd_b_sel,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_b_busy,
    input  logic             issue_valid,
    input  logic [2:0]       issue_dest,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [2:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_data,
    output logic [3:0]       num_busy,
    output logic             err_wb_idle
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    busy_vec_t                      busy;
    busy_vec_t                      busy_next;
    logic [CNT_W-1:0]               num_busy_next;
    logic                           err_next;
    logic [WIDTH-1:0]               mux_a_data;
    logic [WIDTH-1:0]               mux_b_data;
    logic                           hit_a;
    logic                           hit_b;
    logic                           hit_issue;
    logic                           fire;
    logic                           clear;

    regfile8_scoreboard_mux8 #(.WIDTH(WIDTH)) u_mux_a (
        .data_in  (regs),
        .sel      (rd_a_sel),
        .data_out (mux_a_data)
    );

    regfile8_scoreboard_mux8 #(.WIDTH(WIDTH)) u_mux_b (
        .data_in  (regs),
        .sel      (rd_b_sel),
        .data_out (mux_b_data)
    );

    // Read bypass, issue readiness and next scoreboard state.
    always_comb begin
        hit_a         = wb_valid && (wb_dest == rd_a_sel);
        hit_b         = wb_valid && (wb_dest == rd_b_sel);
        hit_issue     = wb_valid && (wb_dest == issue_dest);

        rd_a_data     = hit_a ? wb_data : mux_a_data;
        rd_b_data     = hit_b ? wb_data : mux_b_data;
        rd_a_busy     = busy[rd_a_sel] && !hit_a;
        rd_b_busy     = busy[rd_b_sel] && !hit_b;

        // A same-cycle writeback to the destination frees it for re-reservation.
        issue_ready   = !busy[issue_dest] || hit_issue;
        fire          = issue_valid && issue_ready;
        clear         = wb_valid && busy[wb_dest];

        // Clear first so a same-register issue leaves the bit set.
        busy_next     = busy;
        if (wb_valid) begin
            busy_next[wb_dest] = 1'b0;
        end
        if (fire) begin
            busy_next[issue_dest] = 1'b1;
        end

        // A busy register cannot be re-reserved, so the count stays within 0..8.
        num_busy_next = num_busy + CNT_W'(fire) - CNT_W'(clear);
        err_next      = err_wb_idle || (wb_valid && !busy[wb_dest]);
    end

    // Storage, scoreboard, busy counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= RESET_VAL;
            end
            busy        <= '0;
            num_busy    <= '0;
            err_wb_idle <= 1'b0;
        end else begin
            if (wb_valid) begin
                regs[wb_dest] <= wb_data;
            end
            busy        <= busy_next;
            num_busy    <= num_busy_next;
            err_wb_idle <= err_next;
        end
    end

endmodule : regfile8_scoreboard
